// File: rtl/acc_outstanding_cnt.sv
// Saturating up/down counter of in-flight accelerator memory ops.
// err flags an increment at MAX or a decrement at zero; the count holds in both cases.
module acc_outstanding_cnt #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         full,
  output logic         err
);

  always_comb begin
    zero = (cnt == '0);
    full = (cnt == W'(MAX));
    // A simultaneous inc/dec cancels, so it can never be an error.
    err  = (inc & ~dec & full) | (dec & ~inc & zero);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + W'(1);
    end else if (dec && !inc && !zero) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/acc_mem_order_ctrl.sv
// Orders scalar LSU and vector accelerator memory traffic and sequences fences.
// Gating is combinational from registered counts/state plus same-cycle dispatches.
module acc_mem_order_ctrl #(
  parameter  int MAX_OUTSTANDING = 8,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             acc_ld_disp_i,
  input  logic             acc_st_disp_i,
  input  logic             acc_ld_complete_i,
  input  logic             acc_st_complete_i,
  input  logic             lsu_valid_i,
  input  logic             lsu_is_store_i,
  input  logic             lsu_ready_i,
  output logic             lsu_valid_o,
  output logic             lsu_ready_o,
  input  logic             lsu_st_pending_i,
  input  logic             acc_valid_i,
  input  logic             acc_is_mem_i,
  input  logic             acc_is_store_i,
  input  logic             acc_ready_i,
  output logic             acc_valid_o,
  output logic             acc_ready_o,
  input  logic             fence_req_i,
  output logic             fence_done_o,
  output logic [CNT_W-1:0] ld_cnt_o,
  output logic [CNT_W-1:0] st_cnt_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} fence_state_e;

  fence_state_e state_q, state_d;
  logic ld_zero, ld_full, ld_err;
  logic st_zero, st_full, st_err;
  logic err_q;
  logic drain, blk_s, blk_a;

  acc_outstanding_cnt #(.MAX(MAX_OUTSTANDING), .W(CNT_W)) u_ld_cnt (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .inc  (acc_ld_disp_i),
    .dec  (acc_ld_complete_i),
    .cnt  (ld_cnt_o),
    .zero (ld_zero),
    .full (ld_full),
    .err  (ld_err)
  );

  acc_outstanding_cnt #(.MAX(MAX_OUTSTANDING), .W(CNT_W)) u_st_cnt (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .inc  (acc_st_disp_i),
    .dec  (acc_st_complete_i),
    .cnt  (st_cnt_o),
    .zero (st_zero),
    .full (st_full),
    .err  (st_err)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | ld_err | st_err;
    end
  end

  always_comb begin
    state_d      = state_q;
    fence_done_o = 1'b0;
    case (state_q)
      IDLE:  if (fence_req_i) state_d = DRAIN;
      DRAIN: begin
        // Flush wins over completion so an aborted fence never reports done.
        if (flush_i) begin
          state_d = IDLE;
        end else if (ld_zero && st_zero && !lsu_st_pending_i &&
                     !acc_ld_disp_i && !acc_st_disp_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        fence_done_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drain = (state_q == DRAIN);
    // Scalar stores wait for all vector traffic; scalar loads only for vector stores.
    if (lsu_is_store_i) begin
      blk_s = drain | ~ld_zero | ~st_zero | acc_ld_disp_i | acc_st_disp_i;
    end else begin
      blk_s = drain | ~st_zero | acc_st_disp_i;
    end
    blk_a = drain | (acc_is_mem_i &
                     (lsu_st_pending_i | (acc_is_store_i ? st_full : ld_full)));
    lsu_valid_o = lsu_valid_i & ~blk_s;
    lsu_ready_o = lsu_ready_i & ~blk_s;
    acc_valid_o = acc_valid_i & ~blk_a;
    acc_ready_o = acc_ready_i & ~blk_a;
    err_o       = err_q;
  end

endmodule
